// File: rtl/byte_capture_fifo.sv
// rtl/byte_capture_fifo.sv - enable-qualified byte capture into a FWFT FIFO with debug counters
//
// Purpose:
//   Captures each data_in word offered with en_in=1 into a small first-word-fall-through
//   FIFO and hands captured words downstream over a valid/ready handshake. Saturating
//   counters track accepted (capt_cnt) and rejected (drop_cnt) offers.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   data_in    word from the upstream stage
//   en_in      write qualifier; word is offered when 1
//   out_data   head-of-FIFO word, 0 when empty
//   out_valid  head word is valid
//   out_ready  downstream accepts the head word
//   full       FIFO holds DEPTH entries
//   empty      FIFO holds no entries
//   level      current occupancy, 0..DEPTH
//   capt_cnt   accepted writes, saturating
//   drop_cnt   offered-but-rejected writes, saturating

module byte_capture_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       en_in,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           capt_cnt,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic [CNT_W-1:0] capt_q,   capt_d;
    logic [CNT_W-1:0] drop_q,   drop_d;

    logic full_w;
    logic empty_w;
    logic pop;
    logic push;

    // Status is decoded purely from the registered occupancy.
    assign full_w  = (level_q == LW'(DEPTH));
    assign empty_w = (level_q == '0);

    assign pop  = !empty_w && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts a write
    // while the head is being taken.
    assign push = en_in && (!full_w || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        capt_d   = capt_q;
        drop_d   = drop_q;

        // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        level_d = level_q + LW'(push) - LW'(pop);

        if (push && (capt_q != '1)) begin
            capt_d = capt_q + CNT_W'(1);
        end
        if (en_in && !push && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            capt_q   <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            capt_q   <= capt_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is never cleared; occupancy alone decides what is valid. Writes are
    // blocked during reset so a reset edge leaves the array untouched.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign out_valid = !empty_w;
    assign out_data  = empty_w ? '0 : mem_q[rd_ptr_q];
    assign full      = full_w;
    assign empty     = empty_w;
    assign level     = level_q;
    assign capt_cnt  = capt_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_byte_capture_fifo.sv
// tb/tb_byte_capture_fifo.sv - randomized and directed self-checking bench for byte_capture_fifo

module tb_byte_capture_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       en_in = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic [7:0] capt_cnt;
    logic [7:0] drop_cnt;

    byte_capture_fifo #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .en_in     (en_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .capt_cnt  (capt_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: an ordered list of stored bytes plus two counters.
    logic [7:0] mq[$];
    int         m_capt = 0;
    int         m_drop = 0;
    bit         model_ok = 1'b0;

    // DUT-side pop observation for ordering checks.
    bit         pop_seen;
    logic [7:0] pop_byte;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit m_pop;
        bit m_push;
        if (!rst_n) begin
            mq.delete();
            m_capt = 0;
            m_drop = 0;
            model_ok = 1'b1;
        end else begin
            m_pop  = (mq.size() > 0) && out_ready;
            m_push = en_in && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back(data_in);
                if (m_capt < 255) m_capt++;
            end else if (en_in) begin
                if (m_drop < 255) m_drop++;
            end
        end
    endtask

    // One clock cycle with the given inputs; returns 1 ns after the edge.
    task automatic cyc(input bit en, input logic [7:0] d, input bit rdy);
        en_in     = en;
        data_in   = d;
        out_ready = rdy;
        pop_seen  = out_valid && rdy && rst_n;
        pop_byte  = out_data;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                chk("out_valid", int'(out_valid), int'(mq.size() > 0));
                chk("out_data", int'(out_data), (mq.size() > 0) ? int'(mq[0]) : 0);
                chk("level", int'(level), mq.size());
                chk("full", int'(full), int'(mq.size() == DEPTH));
                chk("empty", int'(empty), int'(mq.size() == 0));
                chk("capt_cnt", int'(capt_cnt), m_capt);
                chk("drop_cnt", int'(drop_cnt), m_drop);
            end
        end
    end

    initial begin
        int         nxt;
        int         got;
        logic [7:0] seq4 [4];

        // Reset then idle
        do_reset(2);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_capt", int'(capt_cnt), 0);
        chk("rst_drop", int'(drop_cnt), 0);

        // Single capture
        cyc(1'b1, 8'h69, 1'b0);
        chk("single_valid", int'(out_valid), 1);
        chk("single_data", int'(out_data), 'h69);
        chk("single_level", int'(level), 1);
        chk("single_capt", int'(capt_cnt), 1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("single_empty", int'(empty), 1);

        // Fill and overflow
        do_reset(1);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i * 'h11), 1'b0);
        chk("fill_full", int'(full), 1);
        chk("fill_level", int'(level), 4);
        cyc(1'b1, 8'h55, 1'b0);
        chk("ovf_drop", int'(drop_cnt), 1);
        chk("ovf_capt", int'(capt_cnt), 4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", int'(out_data), i * 'h11);
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("drain_empty", int'(empty), 1);

        // Full with simultaneous push and pop
        do_reset(1);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i * 'h11), 1'b0);
        cyc(1'b1, 8'h55, 1'b1);
        chk("pp_level", int'(level), 4);
        chk("pp_full", int'(full), 1);
        chk("pp_drop", int'(drop_cnt), 0);
        seq4[0] = 8'h22; seq4[1] = 8'h33; seq4[2] = 8'h44; seq4[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain", int'(out_data), int'(seq4[i]));
            cyc(1'b0, 8'h00, 1'b1);
        end

        // Wrap-around: bytes offered on even cycles, ready on odd cycles
        do_reset(1);
        nxt = 0;
        got = 0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            if ((c % 2 == 0) && nxt < 10) begin
                cyc(1'b1, 8'(nxt), 1'b0);
                nxt++;
            end else begin
                cyc(1'b0, 8'h00, 1'b1);
            end
            if (pop_seen) begin
                chk("wrap_order", int'(pop_byte), got);
                got++;
            end
        end
        chk("wrap_count", got, 10);
        chk("wrap_drop", int'(drop_cnt), 0);

        // Reset mid-operation
        do_reset(1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
        chk("mid_level", int'(level), 3);
        rst_n = 1'b0;
        cyc(1'b1, 8'h77, 1'b1);
        rst_n = 1'b1;
        chk("mid_empty", int'(empty), 1);
        chk("mid_data", int'(out_data), 0);
        chk("mid_capt", int'(capt_cnt), 0);
        chk("mid_drop", int'(drop_cnt), 0);
        cyc(1'b1, 8'hA5, 1'b0);
        chk("mid_first", int'(out_data), 'hA5);

        // Counter saturation
        do_reset(1);
        for (int i = 0; i < 300; i++) cyc(1'b1, 8'(i), 1'b0);
        chk("sat_drop", int'(drop_cnt), 255);
        for (int i = 0; i < 300; i++) cyc(1'b1, 8'(i), 1'b1);
        chk("sat_capt", int'(capt_cnt), 255);
        chk("sat_drop_hold", int'(drop_cnt), 255);

        // Randomized traffic, with unknown data when not enabled and rare resets
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            bit         en;
            bit         rdy;
            logic [7:0] d;
            en  = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 45);
            d   = en ? 8'($urandom) : 8'hxx;
            if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            cyc(en, d, rdy);
            rst_n = 1'b1;
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
